// File: rtl/hc_mmio_rd_responder.sv
// MMIO read responder: decodes CCI-P c0 MMIO reads against the AFU header and
// HardCloud CSRs and returns the data on c2 through a fixed 3-stage pipeline.

package ccip_if_pkg;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [63:0]  t_ccip_mmioData;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [15:0]  t_ccip_mmioAddr;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    t_ccip_clData        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;
endpackage

module hc_mmio_rd_responder
  import ccip_if_pkg::*;
#(
  parameter int unsigned HC_BUFFER_SIZE = 2,
  parameter logic [63:0] AFU_ID_L       = 64'h0,
  parameter logic [63:0] AFU_ID_H       = 64'h0,
  parameter logic [63:0] DFH_VALUE      = 64'h1000_0000_0000_0000
) (
  input  logic                         clk,
  input  logic                         SoftReset_n,
  input  t_if_ccip_c0_Rx               cp2af_sRx_c0,
  output t_if_ccip_c2_Tx               af2cp_sTx_c2,
  input  logic [63:0]                  csr_dsm_base,
  input  logic [31:0]                  csr_control,
  input  logic [HC_BUFFER_SIZE*96-1:0] csr_buffer,
  input  logic [63:0]                  csr_status
);

  // Qword indices (byte address >> 3) of the register map
  localparam logic [14:0] QA_DFH      = 15'h000;
  localparam logic [14:0] QA_ID_L     = 15'h001;
  localparam logic [14:0] QA_ID_H     = 15'h002;
  localparam logic [14:0] QA_RSVD0    = 15'h003;
  localparam logic [14:0] QA_RSVD1    = 15'h004;
  localparam logic [14:0] QA_DSM      = 15'h022;
  localparam logic [14:0] QA_CONTROL  = 15'h023;
  localparam logic [14:0] QA_BUF_BASE = 15'h024;
  localparam logic [14:0] QA_STATUS   = 15'h030;
  localparam logic [14:0] QA_RD_CNT   = 15'h031;
  localparam logic [14:0] QA_UNMAP    = 15'h032;

  // S1: registered request
  logic           s1_valid;
  t_ccip_mmioAddr s1_addr;
  logic [1:0]     s1_len;
  t_ccip_tid      s1_tid;

  // S2: decoded, width-adjusted data
  logic           s2_valid;
  t_ccip_tid      s2_tid;
  logic [63:0]    s2_data;

  logic [31:0]    rd_count;
  logic [31:0]    unmapped_count;

  logic [14:0]    s1_qaddr;
  logic [63:0]    reg_val;
  logic [63:0]    rsp_data;
  logic           hit;

  logic unused_c0;
  assign unused_c0 = ^{cp2af_sRx_c0.data, cp2af_sRx_c0.rspValid,
                       cp2af_sRx_c0.mmioWrValid, cp2af_sRx_c0.hdr.rsvd};

  assign s1_qaddr = s1_addr[15:1];

  always_comb begin
    reg_val = '0;
    hit     = 1'b1;
    unique case (s1_qaddr)
      QA_DFH:             reg_val = DFH_VALUE;
      QA_ID_L:            reg_val = AFU_ID_L;
      QA_ID_H:            reg_val = AFU_ID_H;
      QA_RSVD0, QA_RSVD1: reg_val = '0;
      QA_DSM:             reg_val = csr_dsm_base;
      QA_CONTROL:         reg_val = {32'h0, csr_control};
      QA_STATUS:          reg_val = csr_status;
      QA_RD_CNT:          reg_val = {32'h0, rd_count};
      QA_UNMAP:           reg_val = {32'h0, unmapped_count};
      default: begin
        hit = 1'b0;
        // Buffer i occupies an address/size qword pair starting at 0x120
        for (int unsigned i = 0; i < HC_BUFFER_SIZE; i++) begin
          if (s1_qaddr == 15'(QA_BUF_BASE + 2 * i)) begin
            reg_val = csr_buffer[i*96+32 +: 64];
            hit     = 1'b1;
          end
          if (s1_qaddr == 15'(QA_BUF_BASE + 2 * i + 1)) begin
            reg_val = {32'h0, csr_buffer[i*96 +: 32]};
            hit     = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    rsp_data = reg_val;
    if (s1_len == 2'd0)
      rsp_data = s1_addr[0] ? {32'h0, reg_val[63:32]} : {32'h0, reg_val[31:0]};
  end

  always_ff @(posedge clk) begin
    if (!SoftReset_n) begin
      s1_valid       <= 1'b0;
      s1_addr        <= '0;
      s1_len         <= '0;
      s1_tid         <= '0;
      s2_valid       <= 1'b0;
      s2_tid         <= '0;
      s2_data        <= '0;
      af2cp_sTx_c2   <= '0;
      rd_count       <= '0;
      unmapped_count <= '0;
    end else begin
      s1_valid <= cp2af_sRx_c0.mmioRdValid;
      s1_addr  <= cp2af_sRx_c0.hdr.address;
      s1_len   <= cp2af_sRx_c0.hdr.length;
      s1_tid   <= cp2af_sRx_c0.hdr.tid;

      s2_valid <= s1_valid;
      s2_tid   <= s1_tid;
      s2_data  <= rsp_data;

      af2cp_sTx_c2.mmioRdValid <= s2_valid;
      af2cp_sTx_c2.hdr.tid     <= s2_tid;
      af2cp_sTx_c2.data        <= s2_data;

      // Counted as the response leaves S3, so a 0x188 read sees only earlier exits
      rd_count       <= rd_count + 32'(af2cp_sTx_c2.mmioRdValid);
      unmapped_count <= unmapped_count + 32'(s1_valid && !hit);
    end
  end

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// Directed bench for hc_mmio_rd_responder: cycle-exact burst checks of c2
// against hand-computed register values.

module tb_hc_mmio_rd_responder;
  import ccip_if_pkg::*;

  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DFH  = 64'h1000_0000_0000_0000;
  localparam logic [63:0] DSM  = 64'h1122_3344_5566_7788;
  localparam logic [63:0] STAT = 64'h0000_0000_0000_0001;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  t_if_ccip_c0_Rx   c0;
  t_if_ccip_c2_Tx   c2;
  logic [63:0]      csr_dsm_base;
  logic [31:0]      csr_control;
  logic [2*96-1:0]  csr_buffer;
  logic [63:0]      csr_status;

  int n_pass  = 0;
  int n_total = 0;

  logic        b_rd   [16];
  logic        b_wr   [16];
  logic [15:0] b_addr [16];
  logic [1:0]  b_len  [16];
  logic [8:0]  b_tid  [16];
  logic [63:0] b_exp  [16];

  hc_mmio_rd_responder #(
    .HC_BUFFER_SIZE (2),
    .AFU_ID_L       (ID_L),
    .AFU_ID_H       (ID_H)
  ) dut (
    .clk          (clk),
    .SoftReset_n  (rst_n),
    .cp2af_sRx_c0 (c0),
    .af2cp_sTx_c2 (c2),
    .csr_dsm_base (csr_dsm_base),
    .csr_control  (csr_control),
    .csr_buffer   (csr_buffer),
    .csr_status   (csr_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic set_req(input int idx, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [1:0] len,
                         input logic [8:0] tid, input logic [63:0] exp);
    b_rd[idx] = rd; b_wr[idx] = wr; b_addr[idx] = addr;
    b_len[idx] = len; b_tid[idx] = tid; b_exp[idx] = exp;
  endtask

  // Entry i is launched just after edge i; its response must be visible just
  // after edge i+3 and nowhere else.
  task automatic run_burst(input string tag, input int n);
    for (int i = 0; i <= n + 3; i++) begin
      int j;
      @(posedge clk);
      #1;
      c0 = '0;
      if (i < n) begin
        c0.mmioRdValid    = b_rd[i];
        c0.mmioWrValid    = b_wr[i];
        c0.hdr.address    = b_addr[i];
        c0.hdr.length     = b_len[i];
        c0.hdr.tid        = b_tid[i];
        c0.data           = {8{64'hBAD0_BAD0_BAD0_BAD0}};
      end
      j = i - 3;
      if (j >= 0 && j < n && b_rd[j]) begin
        check($sformatf("%s[%0d].valid", tag, j), 64'(c2.mmioRdValid), 64'd1);
        check($sformatf("%s[%0d].tid", tag, j), 64'(c2.hdr.tid), 64'(b_tid[j]));
        check($sformatf("%s[%0d].data", tag, j), c2.data, b_exp[j]);
      end else begin
        check($sformatf("%s.idle@%0d", tag, i), 64'(c2.mmioRdValid), 64'd0);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    c0 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset.c2_zero", {c2.data[54:0], c2.hdr.tid}, 64'd0);
    check("reset.c2_data_hi", 64'(c2.data[63:55]) | 64'(c2.mmioRdValid), 64'd0);
  endtask

  initial begin
    c0           = '0;
    csr_dsm_base = DSM;
    csr_control  = 32'd3;
    csr_status   = STAT;
    csr_buffer   = {64'hDEAD_BEEF_0000_1000, 32'h0000_0400,
                    64'hAAAA_BBBB_CCCC_0000, 32'h0000_0040};

    do_reset();

    // Header read, latency and idle c2 beforehand
    set_req(0, 1, 0, 16'h0000, 2'd1, 9'h1A5, DFH);
    run_burst("hdr", 1);

    // Buffer and control readback
    set_req(0, 1, 0, 16'h004C, 2'd1, 9'h010, 64'hDEAD_BEEF_0000_1000);
    set_req(1, 1, 0, 16'h004E, 2'd1, 9'h011, 64'h0000_0000_0000_0400);
    set_req(2, 1, 0, 16'h0046, 2'd1, 9'h012, 64'h0000_0000_0000_0003);
    run_burst("bufctl", 3);

    // 32-bit halves, full read ignoring address[0], write-only ignored
    set_req(0, 1, 0, 16'h0044, 2'd0, 9'h020, 64'h0000_0000_5566_7788);
    set_req(1, 1, 0, 16'h0045, 2'd0, 9'h021, 64'h0000_0000_1122_3344);
    set_req(2, 1, 0, 16'h0045, 2'd2, 9'h022, DSM);
    set_req(3, 0, 1, 16'h0000, 2'd1, 9'h023, 64'h0);
    set_req(4, 1, 1, 16'h0060, 2'd3, 9'h024, STAT);
    run_burst("len", 5);

    // Back-to-back with counter check from a clean reset
    do_reset();
    set_req(0, 1, 0, 16'h0000, 2'd1, 9'd0, DFH);
    set_req(1, 1, 0, 16'h0002, 2'd1, 9'd1, ID_L);
    set_req(2, 1, 0, 16'h0004, 2'd1, 9'd2, ID_H);
    set_req(3, 1, 0, 16'h0044, 2'd1, 9'd3, DSM);
    set_req(4, 1, 0, 16'h0046, 2'd1, 9'd4, 64'h3);
    set_req(5, 1, 0, 16'h0048, 2'd1, 9'd5, 64'hAAAA_BBBB_CCCC_0000);
    set_req(6, 1, 0, 16'h004A, 2'd1, 9'd6, 64'h40);
    set_req(7, 1, 0, 16'h0060, 2'd1, 9'd7, STAT);
    run_burst("b2b", 8);
    set_req(0, 1, 0, 16'h0062, 2'd1, 9'h030, 64'd8);
    run_burst("rdcnt", 1);

    // Unmapped / out-of-range, plus a mapped zero register
    set_req(0, 1, 0, 16'h003E, 2'd1, 9'h040, 64'h0);
    set_req(1, 1, 0, 16'h0200, 2'd1, 9'h041, 64'h0);
    set_req(2, 1, 0, 16'h0006, 2'd1, 9'h042, 64'h0);
    run_burst("unmap", 3);
    set_req(0, 1, 0, 16'h0064, 2'd1, 9'h043, 64'd2);
    run_burst("unmapcnt", 1);

    // Reset mid-flight: two reads in flight plus one presented during reset
    @(posedge clk);
    #1 c0 = '0; c0.mmioRdValid = 1'b1; c0.hdr.length = 2'd1; c0.hdr.tid = 9'h051;
    @(posedge clk);
    #1 c0.hdr.tid = 9'h052; c0.hdr.address = 16'h0044;
    @(posedge clk);
    #1 rst_n = 1'b0; c0.hdr.tid = 9'h053;
    check("midrst.e2", 64'(c2.mmioRdValid), 64'd0);
    @(posedge clk);
    #1 c0 = '0;
    check("midrst.e3", 64'(c2.mmioRdValid), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("midrst.post%0d", k), 64'(c2.mmioRdValid), 64'd0);
      @(posedge clk);
      #1;
    end
    set_req(0, 1, 0, 16'h0062, 2'd1, 9'h060, 64'd0);
    set_req(1, 1, 0, 16'h0064, 2'd1, 9'h061, 64'd0);
    run_burst("cnt_clr", 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
